instr_fetch: RTL

INSTR_FETCH -- requirements
Module: instr_fetch

---
 rtl/instr_fetch_pkg.sv | 24 ++
 rtl/instr_fetch_fifo.sv | 43 ++++
 rtl/instr_fetch.sv | 116 +++++++++++
 3 files changed

// File: rtl/instr_fetch_pkg.sv
// Shared definitions for the instruction fetch unit and the control unit:
// opcode values, opcode field width and fetch state encoding.
package instr_fetch_pkg;

   // The opcode occupies the top OPC_W bits of every instruction word.
   localparam int OPC_W = 5;

   localparam logic [OPC_W-1:0] OP_ENDOP = 5'd31;
   localparam logic [OPC_W-1:0] OP_NOP   = 5'd28;
   localparam logic [OPC_W-1:0] OP_JPNZ  = 5'd24;
   localparam logic [OPC_W-1:0] OP_JMPZ  = 5'd26;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      DRAIN = 2'd2,
      HALT  = 2'd3
   } fetch_state_t;

   function automatic logic is_endop(input logic [OPC_W-1:0] opc);
      return opc == OP_ENDOP;
   endfunction

endpackage

// File: rtl/instr_fetch_fifo.sv
// Two-entry queue of fetched {pc, instr} pairs; head is visible combinationally.
// The caller never pushes into a full queue or pops an empty one.
module fetch_fifo #(
   parameter int WIDTH = 29
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [1:0]       count,
   output logic [WIDTH-1:0] head
);

   logic       wr_ptr_reg;
   logic       rd_ptr_reg;
   logic [1:0] count_reg;

   always_ff @(posedge clk) begin
      if (rst || flush) begin
         wr_ptr_reg <= 1'b0;
         rd_ptr_reg <= 1'b0;
         count_reg  <= 2'd0;
      end else begin
         if (push) wr_ptr_reg <= ~wr_ptr_reg;
         if (pop)  rd_ptr_reg <= ~rd_ptr_reg;
         count_reg <= count_reg + {1'b0, push} - {1'b0, pop};
      end
   end

   for (genvar gi = 0; gi < 2; gi++) begin : g_slot
      logic [WIDTH-1:0] data_reg;
      always_ff @(posedge clk) begin
         if (push && !flush && (wr_ptr_reg == 1'(gi)))
            data_reg <= push_data;
      end
   end

   assign count = count_reg;
   assign head  = rd_ptr_reg ? g_slot[1].data_reg : g_slot[0].data_reg;

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch unit: prefetches into a 2-entry queue, follows redirects,
// and stops after the endop instruction has been handed to the control unit.
module instr_fetch
   import instr_fetch_pkg::*;
#(
   parameter int width_in  = 12,
   parameter int width_out = 17
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   output logic [width_in-1:0]  mem_addr,
   input  logic [width_out-1:0] mem_data,
   output logic [width_out-1:0] instr,
   output logic                 instr_valid,
   input  logic                 instr_ready,
   output logic [width_in-1:0]  pc_out,
   input  logic                 jump_en,
   input  logic [width_in-1:0]  jump_target,
   output logic                 halted
);

   localparam int ENTRY_W = width_in + width_out;
   localparam logic [width_in-1:0] ONE = {{(width_in-1){1'b0}}, 1'b1};

   fetch_state_t          state_reg, state_next;
   logic [width_in-1:0]   fpc_reg, fpc_next;
   logic [width_in-1:0]   tag_reg, tag_next;
   logic                  inflight_reg, inflight_next;

   logic [1:0]            count;
   logic [ENTRY_W-1:0]    head;
   logic [width_out-1:0]  head_instr;
   logic [width_in-1:0]   head_pc;
   logic [2:0]            occ;
   logic                  redirect, push, pop, issue, push_endop;

   fetch_fifo #(.WIDTH(ENTRY_W)) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .flush     (redirect),
      .push      (push),
      .push_data ({tag_reg, mem_data}),
      .pop       (pop),
      .count     (count),
      .head      (head)
   );

   assign {head_pc, head_instr} = head;
   assign instr_valid = (count != 2'd0);
   assign instr       = instr_valid ? head_instr : '0;
   assign pc_out      = instr_valid ? head_pc : '0;
   assign mem_addr    = fpc_reg;
   assign halted      = (state_reg == HALT);

   assign redirect   = jump_en && ((state_reg == FETCH) || (state_reg == DRAIN));
   assign pop        = instr_valid && instr_ready && !jump_en;
   // Returns are only accepted while fetching; in DRAIN they are past the endop.
   assign push       = inflight_reg && (state_reg == FETCH) && !redirect;
   assign push_endop = push && is_endop(mem_data[width_out-1 -: OPC_W]);

   // Slots claimed once this cycle's transfer has freed its entry.
   assign occ   = {1'b0, count} + {2'b0, inflight_reg} - {2'b0, pop};
   assign issue = (state_reg == FETCH) && !redirect && !push_endop && (occ < 3'd2);

   always_comb begin
      state_next    = state_reg;
      fpc_next      = fpc_reg;
      tag_next      = tag_reg;
      inflight_next = 1'b0;
      case (state_reg)
         IDLE, HALT: begin
            if (start) begin
               state_next = FETCH;
               fpc_next   = '0;
            end
         end
         FETCH: begin
            if (redirect) begin
               fpc_next = jump_target;
            end else begin
               if (issue) begin
                  fpc_next      = fpc_reg + ONE;
                  tag_next      = fpc_reg;
                  inflight_next = 1'b1;
               end
               if (push_endop) state_next = DRAIN;
            end
         end
         DRAIN: begin
            if (redirect) begin
               state_next = FETCH;
               fpc_next   = jump_target;
            end else if (pop && is_endop(head_instr[width_out-1 -: OPC_W])) begin
               state_next = HALT;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg    <= IDLE;
         fpc_reg      <= '0;
         tag_reg      <= '0;
         inflight_reg <= 1'b0;
      end else begin
         state_reg    <= state_next;
         fpc_reg      <= fpc_next;
         tag_reg      <= tag_next;
         inflight_reg <= inflight_next;
      end
   end

endmodule
